simplez_uart_tx: RTL
====================

# simplez_uart_tx

Memory-mapped serial transmitter that sits directly downstream of the SIMPLEZ core on its address/data buses. It consumes `ST` writes to its data address and serialises the low 8 bits as 8N1 UART frames on `tx`. It exposes a status word readable with `LD`, so programs can poll before writing. A one-word holding buffer lets the CPU queue one character while the previous one is shifting.

## Interface
- `ADDRW`, 9: address bus width (matches CPU `RA`).
- `DATAW`, 12: data bus width (matches CPU `busD`).
- `BAUD_DIV`, 104: clock cycles per bit (12 MHz / 115200); legal range 2..4095.
- `ADDR_TX`, 9'o101: write-only transmit data address.
- `ADDR_ST`, 9'o102: read-only status address.
- `clk` in 1: system clock; all state updates on the falling edge, matching the CPU datapath.
- `rstn` in 1: reset, asynchronous and active-low.
- `addr` in ADDRW: CPU address register `RA`.
- `data_in` in DATAW: CPU data bus (value of `AC` during `ST`).
- `wr` in 1: CPU write strobe (`esc`).
- `rd` in 1: CPU read strobe (`lec`).
- `data_out` out DATAW: read data, muxed by the top level onto `busD`.
- `tx` out 1: serial line, idle high.
- `busy` out 1: shifter active (frame in progress).

## Operation
- Registers: holding register `hold[7:0]` with `hold_valid`; shift register `sh[7:0]`; bit index `bitn[2:0]`; baud counter `bcnt`; sticky `overrun`.
- Write: `wr=1` and `addr==ADDR_TX` at a falling edge → `hold<=data_in[7:0]`, `hold_valid<=1`; `data_in[11:8]` ignored.
- Write with `hold_valid=1` and the hold not being drained at the same edge → write dropped, `overrun<=1`, `hold` unchanged.
- Write at the same edge the hold drains into the shifter → accepted; the new value becomes `hold`.
- Status read: `data_out = {9'b0, overrun, busy, ~hold_valid}` when `addr==ADDR_ST`; otherwise 0. This path is combinational.
- `rd=1` with `addr==ADDR_ST` clears `overrun` at that edge. A simultaneous overrun event wins, leaving `overrun=1`.
- FSM states:
  - IDLE (`tx=1`): if `hold_valid` → load `sh`, clear `hold_valid`, go to START.
  - START (`tx=0`, BAUD_DIV cycles) → DATA with `bitn=0`.
  - DATA (`tx=sh[0]`, LSB first, BAUD_DIV cycles per bit, shift right after each bit): after bit 7 → STOP.
  - STOP (`tx=1`, BAUD_DIV cycles): if `hold_valid` → load and go to START directly (no idle gap); else go to IDLE.
- `bcnt` reloads to BAUD_DIV-1 on every state or bit entry and counts down; the bit ends at 0.
- `tx` is driven from a register, so there are no glitches.
- `busy = (state != IDLE)`.

## Timing
- Reset values: `tx=1`, `busy=0`, `data_out=0` (for `addr != ADDR_ST`), `overrun=0`, `hold_valid=0`, state IDLE.
- Reset mid-frame aborts the frame immediately: `tx` goes high asynchronously and no partial data is resumed.
- Latency: on a write edge with the FSM idle, `tx` falls at the next falling edge (1 cycle).
- Frame length: exactly 10×BAUD_DIV cycles from `tx` falling to the end of the stop bit.
- Back-to-back: the second start bit begins at the edge immediately after the last stop-bit cycle.
- Status reflects a write at the edge after it, which suits the CPU's O0/O1 sequence.

## Structure
- Shared include `simplez_defs.vh` holds memory-map constants (LEDs 9'o100, `ADDR_TX`, `ADDR_ST`) and the status bit positions, shared with the core's chip-select decoding.
- One sub-module, `uart_baud_gen`: the reloadable BAUD_DIV down-counter producing a one-cycle `tick`, restartable by `load`.
- The top level ORs `data_out` into the core's `busD` memory-read mux.

## Test plan
Run all scenarios with BAUD_DIV=4 unless noted.
- Reset then idle 50 cycles → `tx=1`, `busy=0`, status read returns 12'o001.
- Write 12'h7A5 to 9'o101 → `tx` low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), high stop 4 cycles; frame is 40 cycles; `busy` high throughout.
- Write 0x41, then 0x42 during the start bit → status reads 12'o002 (busy, not ready); two contiguous frames with no idle gap between them; `overrun` stays 0.
- Write 0x41, 0x42, 0x43 during the first frame → 0x43 dropped; status reads 12'o006; `rd` at 9'o102 clears it to 12'o002; only 0x41 and 0x42 are transmitted.
- Assert `rstn=0` in the middle of bit 3 → `tx=1` at once; after release, status reads 12'o001 and no further toggles on `tx`.
- BAUD_DIV=104: single frame lasts exactly 1040 cycles, with bit centres at 52+104k.

Source files
------------

// File: rtl/simplez_uart_tx_pkg.sv
// Shared definitions for the SIMPLEZ UART transmitter: memory map,
// status word layout and the transmit state encoding.
package simplez_uart_tx_pkg;

  localparam int ADDRW_DEF    = 9;
  localparam int DATAW_DEF    = 12;
  localparam int BAUD_DIV_DEF = 104;
  localparam int BCNT_W       = 12;

  localparam logic [8:0] ADDR_TX_DEF = 9'o101;
  localparam logic [8:0] ADDR_ST_DEF = 9'o102;

  localparam int ST_READY_BIT   = 0;
  localparam int ST_BUSY_BIT    = 1;
  localparam int ST_OVERRUN_BIT = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [11:0] status_word(input logic ovr, input logic bsy, input logic rdy);
    logic [11:0] w;
    w                 = 12'd0;
    w[ST_OVERRUN_BIT] = ovr;
    w[ST_BUSY_BIT]    = bsy;
    w[ST_READY_BIT]   = rdy;
    return w;
  endfunction

endpackage

// File: rtl/simplez_uart_tx_baud_gen.sv
// Baud generator: reloadable BAUD_DIV down-counter; tick marks the last
// cycle of the current bit period.
module simplez_uart_tx_baud_gen #(
  parameter int BAUD_DIV = 104,
  parameter int CNTW     = 12
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_load,
  output logic o_tick
);

  localparam logic [CNTW-1:0] RELOAD = CNTW'(BAUD_DIV - 1);

  logic [CNTW-1:0] r_cnt;

  // Reload on every bit/state entry, otherwise count down and park at zero.
  always_ff @(negedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= {CNTW{1'b0}};
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != {CNTW{1'b0}}) begin
      r_cnt <= r_cnt - CNTW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tick = (r_cnt == {CNTW{1'b0}});

endmodule

// File: rtl/simplez_uart_tx.sv
// Memory-mapped 8N1 transmitter for the SIMPLEZ core: one-word holding
// buffer, falling-edge datapath, combinational status read.
module simplez_uart_tx
  import simplez_uart_tx_pkg::*;
#(
  parameter int               ADDRW    = ADDRW_DEF,
  parameter int               DATAW    = DATAW_DEF,
  parameter int               BAUD_DIV = BAUD_DIV_DEF,
  parameter logic [ADDRW-1:0] ADDR_TX  = ADDRW'(ADDR_TX_DEF),
  parameter logic [ADDRW-1:0] ADDR_ST  = ADDRW'(ADDR_ST_DEF)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] data_in,
  input  logic             wr,
  input  logic             rd,
  output logic [DATAW-1:0] data_out,
  output logic             tx,
  output logic             busy
);

  tx_state_e  r_state, w_state_nxt;
  logic [7:0] r_sh, w_sh_nxt;
  logic [2:0] r_bitn, w_bitn_nxt;
  logic       r_tx, w_tx_nxt;
  logic [7:0] r_hold;
  logic       r_hold_valid;
  logic       r_overrun;

  logic w_load, w_tick, w_drain;
  logic w_wr_tx, w_rd_st, w_ovr_evt, w_accept;
  logic w_unused_hi;

  assign w_unused_hi = ^data_in[DATAW-1:8];

  assign w_wr_tx   = wr && (addr == ADDR_TX);
  assign w_rd_st   = rd && (addr == ADDR_ST);
  assign w_accept  = w_wr_tx && (!r_hold_valid || w_drain);
  assign w_ovr_evt = w_wr_tx && r_hold_valid && !w_drain;

  simplez_uart_tx_baud_gen #(
    .BAUD_DIV (BAUD_DIV),
    .CNTW     (BCNT_W)
  ) u_baud (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_load (w_load),
    .o_tick (w_tick)
  );

  // Next-state, shifter and line value; draining the hold happens in IDLE or at the end of STOP.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_bitn_nxt  = r_bitn;
    w_load      = 1'b0;
    w_drain     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_valid) begin
          w_drain     = 1'b1;
          w_sh_nxt    = r_hold;
          w_state_nxt = S_START;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
          w_bitn_nxt  = 3'd0;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_load   = 1'b1;
          w_sh_nxt = {1'b0, r_sh[7:1]};
          if (r_bitn == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bitn_nxt = r_bitn + 3'd1;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_hold_valid) begin
            w_drain     = 1'b1;
            w_sh_nxt    = r_hold;
            w_state_nxt = S_START;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_sh_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // Transmit state and the registered serial line.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_sh    <= 8'd0;
      r_bitn  <= 3'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_bitn  <= w_bitn_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Holding buffer and sticky overrun; a drop at the same edge as a status read keeps overrun set.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold       <= 8'd0;
      r_hold_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold       <= data_in[7:0];
        r_hold_valid <= 1'b1;
      end else if (w_drain) begin
        r_hold_valid <= 1'b0;
      end else begin
        r_hold_valid <= r_hold_valid;
      end
      if (w_ovr_evt) begin
        r_overrun <= 1'b1;
      end else if (w_rd_st) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != S_IDLE);

  // Status word is visible only at the status address so it can be ORed onto busD.
  always_comb begin
    if (addr == ADDR_ST) begin
      data_out = DATAW'(status_word(r_overrun, busy, ~r_hold_valid));
    end else begin
      data_out = {DATAW{1'b0}};
    end
  end

endmodule
